// File: rtl/uart_cmd_driver_if.sv
// Request handshake between a host and uart_cmd_driver: one byte plus a 2-bit command per transfer.
interface uart_cmd_driver_if;
  logic       req_valid;
  logic [1:0] req_cmd;
  logic [7:0] req_data;
  logic       req_ready;

  modport master (output req_valid, output req_cmd, output req_data, input req_ready);
  modport slave  (input req_valid, input req_cmd, input req_data, output req_ready);
endinterface

// File: rtl/uart_cmd_driver.sv
// Host-side driver for the 7-bit UART command bus: turns byte requests into 3-beat command
// sequences and issues the CONFIG reset command on request.
module uart_cmd_driver #(
  parameter int unsigned HoldCycles = 4,
  parameter int unsigned GapCycles  = 2,
  parameter int unsigned ResetHold  = 2
) (
  input  logic               clk,
  input  logic               reset,
  uart_cmd_driver_if.slave   req,
  input  logic               reset_req,
  output logic [6:0]         out7,
  output logic               busy,
  output logic               done_strobe
);

  localparam int unsigned MaxHg   = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
  localparam int unsigned MaxHold = (MaxHg > ResetHold) ? MaxHg : ResetHold;
  localparam int unsigned CntW    = $clog2(MaxHold + 1);

  localparam logic [6:0] IdleWord  = 7'b0000011;
  localparam logic [6:0] ResetWord = {5'b11000, 2'b01};

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StB0   = 3'd1;
  localparam logic [2:0] StB1   = 3'd2;
  localparam logic [2:0] StB2   = 3'd3;
  localparam logic [2:0] StRst  = 3'd4;
  localparam logic [2:0] StGap  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [7:0]      data_q, data_d;
  logic            done_q, done_d;
  logic            cnt_zero;

  assign cnt_zero      = (cnt_q == '0);
  assign req.req_ready = !reset && (state_q == StIdle) && !pending_q && !reset_req;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        // A queued or fresh reset request beats a simultaneous transfer request.
        if (pending_q || reset_req) begin
          state_d   = StRst;
          cnt_d     = CntW'(ResetHold - 1);
          pending_d = 1'b0;
        end else if (req.req_valid) begin
          state_d = StB0;
          cnt_d   = CntW'(HoldCycles - 1);
          cmd_d   = req.req_cmd;
          data_d  = req.req_data;
        end
      end
      StB0, StB1: begin
        if (cnt_zero) begin
          state_d = (state_q == StB0) ? StB1 : StB2;
          cnt_d   = CntW'(HoldCycles - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StB2, StRst: begin
        if (cnt_zero) begin
          state_d = StGap;
          cnt_d   = CntW'(GapCycles - 1);
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_zero) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (state_q != StIdle && reset_req) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      cmd_q     <= 2'b00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    out7 = IdleWord;
    case (state_q)
      StB0:    out7 = {2'b01, data_q[7:5], cmd_q};
      StB1:    out7 = {2'b10, data_q[4:2], cmd_q};
      StB2:    out7 = {3'b001, data_q[1:0], cmd_q};
      StRst:   out7 = ResetWord;
      default: out7 = IdleWord;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign done_strobe = done_q;

endmodule

// File: tb/tb_uart_cmd_driver.sv
// Directed bench for uart_cmd_driver with a queue-based expected-output model checked every cycle.
module tb_uart_cmd_driver;

  localparam int unsigned H = 4;
  localparam int unsigned G = 2;
  localparam int unsigned R = 2;
  localparam logic [6:0] IdleW = 7'h03;
  localparam logic [6:0] RstW  = 7'h61;

  typedef struct packed {
    logic [6:0] w;
    logic       b;
    logic       d;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_req = 1'b0;
  logic [6:0] out7;
  logic busy;
  logic done_strobe;

  uart_cmd_driver_if bus ();

  uart_cmd_driver #(
    .HoldCycles(H),
    .GapCycles (G),
    .ResetHold (R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.slave),
    .reset_req  (rst_req),
    .out7       (out7),
    .busy       (busy),
    .done_strobe(done_strobe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat word from the command-bus encoding: tag, 3-bit field, then the command.
  function automatic logic [6:0] beat_word(input logic [1:0] cmd, input logic [7:0] d,
                                           input int b);
    int tag;
    int field;
    int v;
    if (b == 0) begin
      tag = 1;
      field = (int'(d) / 32) % 8;
    end else if (b == 1) begin
      tag = 2;
      field = (int'(d) / 4) % 8;
    end else begin
      tag = 0;
      field = 4 + (int'(d) % 4);
    end
    v = ((tag * 8 + field) * 4) + int'(cmd);
    return v[6:0];
  endfunction

  exp_t exp_q[$];
  logic m_pend = 1'b0;
  logic model_en = 1'b0;
  exp_t m_e;
  logic m_rdy;

  task automatic push_gap();
    exp_t e;
    for (int i = 0; i < int'(G); i++) begin
      e.w = IdleW;
      e.b = 1'b1;
      e.d = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_xfer(input logic [1:0] cmd, input logic [7:0] d);
    exp_t e;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < int'(H); i++) begin
        e.w = beat_word(cmd, d, b);
        e.b = 1'b1;
        e.d = 1'b0;
        exp_q.push_back(e);
      end
    end
    push_gap();
  endtask

  task automatic push_rst();
    exp_t e;
    for (int i = 0; i < int'(R); i++) begin
      e.w = RstW;
      e.b = 1'b1;
      e.d = 1'b0;
      exp_q.push_back(e);
    end
    push_gap();
  endtask

  always @(negedge clk) begin
    if (model_en) begin
      if (exp_q.size() > 0) begin
        m_e = exp_q.pop_front();
        m_rdy = 1'b0;
        if (rst_req) m_pend = 1'b1;
      end else begin
        m_e = {IdleW, 1'b0, 1'b0};
        m_rdy = !reset && !m_pend && !rst_req;
        if (!reset) begin
          if (m_pend || rst_req) begin
            push_rst();
            m_pend = 1'b0;
          end else if (bus.req_valid) begin
            push_xfer(bus.req_cmd, bus.req_data);
          end
        end
      end
      chk("model_out7", 32'(out7), 32'(m_e.w));
      chk("model_busy", 32'(busy), 32'(m_e.b));
      chk("model_done", 32'(done_strobe), 32'(m_e.d));
      chk("model_ready", 32'(bus.req_ready), 32'(m_rdy));
      if (reset) begin
        exp_q.delete();
        m_pend = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_word(input string name, input logic [6:0] w, input logic b, input logic d);
    @(negedge clk);
    chk({name, "_out7"}, 32'(out7), 32'(w));
    chk({name, "_busy"}, 32'(busy), 32'(b));
    chk({name, "_done"}, 32'(done_strobe), 32'(d));
  endtask

  // Holds valid until ready is seen; returns just after the accepting edge.
  task automatic send(input logic [1:0] cmd, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic exp_beats(input string name, input logic [6:0] w0, input logic [6:0] w1,
                           input logic [6:0] w2);
    logic [6:0] ws[3];
    ws[0] = w0;
    ws[1] = w1;
    ws[2] = w2;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < int'(H); i++) begin
        exp_word(name, ws[b], 1'b1, 1'b0);
        total++;
        if (out7 == RstW) begin
          bad++;
          $display("FAIL %s_not_reset_word act=%0h", name, out7);
        end
      end
    end
    exp_word({name, "_gap0"}, IdleW, 1'b1, 1'b1);
    exp_word({name, "_gap1"}, IdleW, 1'b1, 1'b0);
  endtask

  logic [6:0] seq_w[16];
  logic       seq_b[16];
  logic       seq_d[16];

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_data  = 8'h00;

    chk("pin_a5_b0", 32'(beat_word(2'd0, 8'hA5, 0)), 32'h34);
    chk("pin_a5_b1", 32'(beat_word(2'd0, 8'hA5, 1)), 32'h44);
    chk("pin_a5_b2", 32'(beat_word(2'd0, 8'hA5, 2)), 32'h14);
    chk("pin_ff_b0", 32'(beat_word(2'd1, 8'hFF, 0)), 32'h3D);

    tick();
    model_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset release.
    for (int i = 0; i < 3; i++) begin
      exp_word("idle", IdleW, 1'b0, 1'b0);
      chk("idle_ready", 32'(bus.req_ready), 32'd1);
    end
    tick();

    send(2'd0, 8'hA5);
    exp_beats("data_a5", 7'b0110100, 7'b1000100, 7'b0010100);
    tick();

    send(2'd1, 8'hFF);
    exp_beats("config_ff", 7'h3D, 7'h5D, 7'h1D);
    tick();

    // Reset command from IDLE.
    rst_req = 1'b1;
    @(negedge clk);
    chk("rstreq_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst_req = 1'b0;
    exp_word("rst0", RstW, 1'b1, 1'b0);
    exp_word("rst1", RstW, 1'b1, 1'b0);
    exp_word("rst_gap0", IdleW, 1'b1, 1'b1);
    exp_word("rst_gap1", IdleW, 1'b1, 1'b0);
    exp_word("rst_after", IdleW, 1'b0, 1'b0);
    chk("rst_ready_back", 32'(bus.req_ready), 32'd1);
    tick();

    // Reset request during B1 of PREDIV 0x3C.
    send(2'd2, 8'h3C);
    for (int i = 0; i < int'(H); i++) exp_word("prediv_b0", 7'h26, 1'b1, 1'b0);
    tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      seq_b[i] = 1'b1;
      seq_d[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) seq_w[i] = 7'h5E;
    for (int i = 3; i < 7; i++) seq_w[i] = 7'h12;
    seq_w[7] = IdleW; seq_d[7] = 1'b1;
    seq_w[8] = IdleW;
    seq_w[9] = IdleW; seq_b[9] = 1'b0;
    seq_w[10] = RstW;
    seq_w[11] = RstW;
    seq_w[12] = IdleW; seq_d[12] = 1'b1;
    seq_w[13] = IdleW;
    seq_w[14] = IdleW; seq_b[14] = 1'b0;
    seq_w[15] = IdleW; seq_b[15] = 1'b0;
    for (int i = 0; i < 16; i++) exp_word("prediv_pend", seq_w[i], seq_b[i], seq_d[i]);
    tick();

    // Synchronous reset during B0 discards the transfer and any pending reset.
    send(2'd3, 8'h11);
    exp_word("abort_b0", beat_word(2'd3, 8'h11, 0), 1'b1, 1'b0);
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) exp_word("abort_idle", IdleW, 1'b0, 1'b0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    tick();

    // Reset request and transfer request in the same IDLE cycle.
    bus.req_valid = 1'b1;
    bus.req_cmd   = 2'd0;
    bus.req_data  = 8'h5A;
    rst_req = 1'b1;
    @(negedge clk);
    chk("tie_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    rst_req = 1'b0;
    exp_word("tie_rst0", RstW, 1'b1, 1'b0);
    exp_word("tie_rst1", RstW, 1'b1, 1'b0);
    exp_word("tie_gap0", IdleW, 1'b1, 1'b1);
    exp_word("tie_gap1", IdleW, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) exp_word("tie_idle", IdleW, 1'b0, 1'b0);

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
